// File: rtl/cap_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// cap_frame_serializer_if
//
// Purpose:
//   Bundles the frame-input handshake and the beat-output stream of
//   cap_frame_serializer. Parameters must match the ones given to the
//   serializer that binds the slave modport.
//
// Signals:
//   in_valid   frame present on in_data            (producer -> serializer)
//   in_data    WIDTH*CAP_NUM frame, word k at [k*WIDTH +: WIDTH]
//   in_ready   serializer accepts a frame this cycle (serializer -> producer)
//   out_valid  out_data holds a valid beat          (serializer -> lane drivers)
//   out_data   WIDTH*LANES beat, lane j at [j*WIDTH +: WIDTH]
//   out_ready  lane drivers accept the beat         (lane drivers -> serializer)
//   out_sof    beat 0 of a frame
//   out_eof    last beat of a frame
//   frame_cnt  completed frames, modulo 2^16
//   out_par    even parity of out_data (only when SER_PARITY_EN is defined)
//
// Modports:
//   slave   view taken by the serializer
//   master  view taken by the surrounding producer/consumer logic
//
// Configuration macro: SER_PARITY_EN adds the out_par signal.
// -----------------------------------------------------------------------------
interface cap_frame_serializer_if #(
   parameter int WIDTH   = 4,
   parameter int CAP_NUM = 70,
   parameter int LANES   = 10
);

   logic                       in_valid;
   logic [WIDTH*CAP_NUM-1:0]   in_data;
   logic                       in_ready;
   logic                       out_valid;
   logic [WIDTH*LANES-1:0]     out_data;
   logic                       out_ready;
   logic                       out_sof;
   logic                       out_eof;
   logic [15:0]                frame_cnt;
`ifdef SER_PARITY_EN
   logic                       out_par;
`endif

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready,
      output out_sof,
      output out_eof,
`ifdef SER_PARITY_EN
      output out_par,
`endif
      output frame_cnt
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready,
      input  out_sof,
      input  out_eof,
`ifdef SER_PARITY_EN
      input  out_par,
`endif
      input  frame_cnt
   );

endinterface

// File: rtl/cap_frame_serializer.sv
// -----------------------------------------------------------------------------
// cap_frame_serializer
//
// Purpose:
//   Downstream stage of the 128->70 capacitor MUX. Captures one frame of
//   CAP_NUM capacitor words (WIDTH bits each) and streams it out as
//   BEATS = ceil(CAP_NUM/LANES) beats of LANES words. Lanes past the last
//   capacitor word of the final beat are driven as zeros. A new frame can be
//   accepted in the same cycle the last beat is consumed, so back-to-back
//   frames stream with no bubble.
//
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  asynchronous, active-low reset
//   bus    cap_frame_serializer_if.slave (frame input, beat output,
//          sof/eof markers, completed-frame counter, optional parity)
//
// Parameters:
//   WIDTH    bits per capacitor word
//   CAP_NUM  capacitor words per frame
//   LANES    words per output beat (1 <= LANES <= CAP_NUM)
//
// Configuration macro:
//   SER_PARITY_EN  when defined, bus.out_par carries the even parity of
//                  out_data (0 while out_valid is low).
// -----------------------------------------------------------------------------
module cap_frame_serializer #(
   parameter int WIDTH   = 4,
   parameter int CAP_NUM = 70,
   parameter int LANES   = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   cap_frame_serializer_if.slave       bus
);

   localparam int BEATS = (CAP_NUM + LANES - 1) / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int FW    = WIDTH * CAP_NUM;
   localparam int LW    = WIDTH * LANES;
   localparam int PADW  = LW * BEATS;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [FW-1:0]   frame_q;
   logic [15:0]     frame_cnt_q;

   logic            load;
   logic            last_beat;
   logic            in_ready_w;
   logic            out_valid_w;
   logic            frame_done;
   logic [PADW-1:0] padded;
   logic [LW-1:0]   beat_sel;
   logic [LW-1:0]   out_data_w;

   // -------------------------------------------------------------------------
   // State, beat index, frame buffer and completed-frame counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         frame_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (load) begin
            frame_q <= bus.in_data;
         end
         if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / handshake decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      load        = 1'b0;
      in_ready_w  = 1'b0;
      out_valid_w = 1'b0;
      last_beat   = (beat_q == LAST_BEAT);

      unique case (state_q)
         IDLE: begin
            in_ready_w = 1'b1;
            if (bus.in_valid) begin
               load    = 1'b1;
               state_d = SEND;
               beat_d  = '0;
            end
         end

         SEND: begin
            out_valid_w = 1'b1;
            if (bus.out_ready) begin
               if (last_beat) begin
                  // Last beat consumed: the buffer is free this very cycle,
                  // so a waiting frame is taken without leaving SEND.
                  in_ready_w = 1'b1;
                  beat_d     = '0;
                  if (bus.in_valid) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   assign frame_done = out_valid_w & bus.out_ready & last_beat;

   // -------------------------------------------------------------------------
   // Beat data: the buffer is zero-extended to a whole number of beats so the
   // final beat's unused lanes read as zero without per-lane range checks.
   // -------------------------------------------------------------------------
   always_comb begin
      padded         = '0;
      padded[FW-1:0] = frame_q;
   end

   always_comb begin
      beat_sel = '0;
      for (int unsigned b = 0; b < BEATS; b++) begin
         if (beat_q == BW'(b)) begin
            beat_sel = padded[b*LW +: LW];
         end
      end
   end

   assign out_data_w = out_valid_w ? beat_sel : '0;

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = out_data_w;
   assign bus.out_sof   = out_valid_w & (beat_q == '0);
   assign bus.out_eof   = out_valid_w & last_beat;
   assign bus.frame_cnt = frame_cnt_q;

`ifdef SER_PARITY_EN
   // out_data is already forced to zero when idle, so parity is 0 there too.
   assign bus.out_par = ^out_data_w;
`endif

endmodule

// File: tb/tb_cap_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_cap_frame_serializer
//
// Self-checking bench for cap_frame_serializer. Two instances are used:
// u_a with LANES=10 (7 beats, no padding) and u_b with LANES=16 (5 beats,
// last beat padded). Inputs are driven on the falling edge and outputs are
// checked 1 ns later. Expected beats come from exp_beat(), which picks frame
// word b*lanes+j or zero for lane j of beat b.
// -----------------------------------------------------------------------------
module tb_cap_frame_serializer;

   localparam int W  = 4;
   localparam int CN = 70;
   localparam int FW = W * CN;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   cap_frame_serializer_if #(.WIDTH(W), .CAP_NUM(CN), .LANES(10)) a_if ();
   cap_frame_serializer_if #(.WIDTH(W), .CAP_NUM(CN), .LANES(16)) b_if ();

   cap_frame_serializer #(.WIDTH(W), .CAP_NUM(CN), .LANES(10)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   cap_frame_serializer #(.WIDTH(W), .CAP_NUM(CN), .LANES(16)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [15:0] exp_cnt_a = '0;
   logic [15:0] exp_cnt_b = '0;

   // Reference: lane j of beat b is frame word b*lanes+j, zero past the end.
   function automatic logic [63:0] exp_beat(input logic [FW-1:0] f,
                                            input int lanes, input int b);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < lanes; j++) begin
         if (b * lanes + j < CN) r[j*W +: W] = f[(b*lanes+j)*W +: W];
      end
      return r;
   endfunction

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      for (int k = 0; k < CN; k++) f[k*W +: W] = W'($urandom);
      return f;
   endfunction

   task automatic test_reset();
      rst_n          = 1'b0;
      a_if.in_valid  = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
      b_if.in_valid  = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_if.out_valid); end
      checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_if.in_ready); end
      checks++; if (a_if.out_sof !== 1'b0 || a_if.out_eof !== 1'b0) begin errors++; $display("FAIL reset_sof_eof got %b%b exp 00", a_if.out_sof, a_if.out_eof); end
      checks++; if (a_if.out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", a_if.out_data); end
      checks++; if (a_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", a_if.frame_cnt); end
      checks++; if (b_if.out_valid !== 1'b0 || b_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_b got v%b r%b exp v0 r1", b_if.out_valid, b_if.in_ready); end
`ifdef SER_PARITY_EN
      checks++; if (a_if.out_par !== 1'b0) begin errors++; $display("FAIL reset_par got %b exp 0", a_if.out_par); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      logic [FW-1:0] f;
      logic [63:0]   e;
      for (int k = 0; k < CN; k++) f[k*W +: W] = W'(k);
      a_if.in_valid = 1'b1; a_if.in_data = f; a_if.out_ready = 1'b1;
      #1;
      checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL single_accept_ready got %b exp 1", a_if.in_ready); end
      for (int b = 0; b < 7; b++) begin
         @(negedge clk);
         a_if.in_valid = 1'b0; a_if.in_data = rand_frame();
         #1;
         e = exp_beat(f, 10, b);
         checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", b, a_if.out_valid); end
         checks++; if (a_if.out_data !== e[39:0]) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", b, a_if.out_data, e[39:0]); end
         checks++; if (a_if.out_sof !== (b == 0) || a_if.out_eof !== (b == 6)) begin errors++; $display("FAIL single_sof_eof beat %0d got %b%b exp %b%b", b, a_if.out_sof, a_if.out_eof, b == 0, b == 6); end
         checks++; if (a_if.in_ready !== (b == 6)) begin errors++; $display("FAIL single_in_ready beat %0d got %b exp %b", b, a_if.in_ready, b == 6); end
`ifdef SER_PARITY_EN
         checks++; if (a_if.out_par !== ^e[39:0]) begin errors++; $display("FAIL single_par beat %0d got %b exp %b", b, a_if.out_par, ^e[39:0]); end
`endif
      end
      exp_cnt_a++;
      @(negedge clk); #1;
      checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", a_if.out_valid); end
      checks++; if (a_if.frame_cnt !== exp_cnt_a) begin errors++; $display("FAIL single_cnt got %0d exp %0d", a_if.frame_cnt, exp_cnt_a); end
   endtask

   task automatic test_padding();
      logic [FW-1:0] f;
      logic [63:0]   e;
      f = rand_frame();
      b_if.in_valid = 1'b1; b_if.in_data = f; b_if.out_ready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         b_if.in_valid = 1'b0;
         #1;
         e = exp_beat(f, 16, b);
         checks++; if (b_if.out_valid !== 1'b1 || b_if.out_data !== e) begin errors++; $display("FAIL pad_data beat %0d got v%b %h exp %h", b, b_if.out_valid, b_if.out_data, e); end
         checks++; if (b_if.out_sof !== (b == 0) || b_if.out_eof !== (b == 4)) begin errors++; $display("FAIL pad_sof_eof beat %0d got %b%b", b, b_if.out_sof, b_if.out_eof); end
`ifdef SER_PARITY_EN
         checks++; if (b_if.out_par !== ^e) begin errors++; $display("FAIL pad_par beat %0d got %b exp %b", b, b_if.out_par, ^e); end
`endif
      end
      exp_cnt_b++;
      @(negedge clk); #1;
      checks++; if (b_if.out_valid !== 1'b0 || b_if.frame_cnt !== exp_cnt_b) begin errors++; $display("FAIL pad_end got v%b cnt %0d exp v0 cnt %0d", b_if.out_valid, b_if.frame_cnt, exp_cnt_b); end
   endtask

   task automatic test_backpressure();
      logic [FW-1:0] f;
      logic [63:0]   e;
      int            b;
      int            cyc;
      logic          r;
      // Pass 0: fixed 3-cycle stall on beat 2. Pass 1: random out_ready.
      for (int pass = 0; pass < 2; pass++) begin
         f = rand_frame();
         a_if.in_valid = 1'b1; a_if.in_data = f; a_if.out_ready = 1'b1;
         b = 0; cyc = 0;
         @(negedge clk);
         a_if.in_valid = 1'b0;
         while (b < 7 && cyc < 60) begin
            if (pass == 0) r = !(b == 2 && cyc < 5);
            else           r = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            a_if.out_ready = r;
            a_if.in_valid  = 1'($urandom_range(0, 1));
            a_if.in_data   = rand_frame();
            if (b == 6 && r) a_if.in_valid = 1'b0;
            #1;
            e = exp_beat(f, 10, b);
            checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== e[39:0]) begin errors++; $display("FAIL bp_data pass %0d beat %0d got v%b %h exp %h", pass, b, a_if.out_valid, a_if.out_data, e[39:0]); end
            checks++; if (a_if.out_sof !== (b == 0) || a_if.out_eof !== (b == 6)) begin errors++; $display("FAIL bp_sof_eof pass %0d beat %0d got %b%b", pass, b, a_if.out_sof, a_if.out_eof); end
            checks++; if (a_if.in_ready !== (b == 6 && r)) begin errors++; $display("FAIL bp_in_ready pass %0d beat %0d got %b exp %b", pass, b, a_if.in_ready, b == 6 && r); end
            if (r) b++;
            cyc++;
            @(negedge clk);
         end
         checks++; if (b != 7) begin errors++; $display("FAIL bp_timeout pass %0d beats %0d exp 7", pass, b); end
         exp_cnt_a++;
         a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
         #1;
         checks++; if (a_if.out_valid !== 1'b0 || a_if.frame_cnt !== exp_cnt_a) begin errors++; $display("FAIL bp_end got v%b cnt %0d exp v0 cnt %0d", a_if.out_valid, a_if.frame_cnt, exp_cnt_a); end
      end
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] fr [2];
      logic [63:0]   e;
      fr[0] = rand_frame();
      fr[1] = rand_frame();
      a_if.in_valid = 1'b1; a_if.in_data = fr[0]; a_if.out_ready = 1'b1;
      for (int n = 0; n < 2; n++) begin
         for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            if (n == 0) a_if.in_data = fr[1];
            else        a_if.in_valid = 1'b0;
            #1;
            e = exp_beat(fr[n], 10, b);
            checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== e[39:0]) begin errors++; $display("FAIL b2b_data frame %0d beat %0d got v%b %h exp %h", n, b, a_if.out_valid, a_if.out_data, e[39:0]); end
            checks++; if (a_if.in_ready !== (b == 6)) begin errors++; $display("FAIL b2b_in_ready frame %0d beat %0d got %b exp %b", n, b, a_if.in_ready, b == 6); end
            checks++; if (a_if.out_sof !== (b == 0) || a_if.out_eof !== (b == 6)) begin errors++; $display("FAIL b2b_sof_eof frame %0d beat %0d got %b%b", n, b, a_if.out_sof, a_if.out_eof); end
         end
         exp_cnt_a++;
      end
      @(negedge clk); #1;
      checks++; if (a_if.out_valid !== 1'b0 || a_if.frame_cnt !== exp_cnt_a) begin errors++; $display("FAIL b2b_end got v%b cnt %0d exp v0 cnt %0d", a_if.out_valid, a_if.frame_cnt, exp_cnt_a); end
   endtask

   task automatic test_reset_mid_frame();
      logic [FW-1:0] f;
      logic [63:0]   e;
      f = rand_frame();
      a_if.in_valid = 1'b1; a_if.in_data = f; a_if.out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         a_if.in_valid = 1'b0;
         #1;
         e = exp_beat(f, 10, b);
         checks++; if (a_if.out_data !== e[39:0]) begin errors++; $display("FAIL rstmid_pre beat %0d got %h exp %h", b, a_if.out_data, e[39:0]); end
      end
      rst_n = 1'b0;
      exp_cnt_a = '0; exp_cnt_b = '0;
      #1;
      checks++; if (a_if.out_valid !== 1'b0 || a_if.out_sof !== 1'b0 || a_if.out_eof !== 1'b0) begin errors++; $display("FAIL rstmid_flags got v%b s%b e%b exp 000", a_if.out_valid, a_if.out_sof, a_if.out_eof); end
      checks++; if (a_if.out_data !== '0 || a_if.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_data got %h rdy %b exp 0 rdy 1", a_if.out_data, a_if.in_ready); end
      checks++; if (a_if.frame_cnt !== 16'd0 || b_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", a_if.frame_cnt, b_if.frame_cnt); end
`ifdef SER_PARITY_EN
      checks++; if (a_if.out_par !== 1'b0) begin errors++; $display("FAIL rstmid_par got %b exp 0", a_if.out_par); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         checks++; if (a_if.out_valid !== 1'b0 || a_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_after cycle %0d got v%b cnt %0d exp v0 cnt 0", c, a_if.out_valid, a_if.frame_cnt); end
      end
   endtask

`ifdef SER_PARITY_EN
   task automatic test_parity();
      logic [FW-1:0] f;
      f = '0;
      f[0] = 1'b1;
      b_if.in_valid = 1'b1; b_if.in_data = f; b_if.out_ready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         b_if.in_valid = 1'b0;
         #1;
         checks++; if (b_if.out_par !== (b == 0)) begin errors++; $display("FAIL parity beat %0d got %b exp %b", b, b_if.out_par, b == 0); end
      end
      exp_cnt_b++;
      @(negedge clk); #1;
      checks++; if (b_if.out_par !== 1'b0 || b_if.frame_cnt !== exp_cnt_b) begin errors++; $display("FAIL parity_idle got p%b cnt %0d exp p0 cnt %0d", b_if.out_par, b_if.frame_cnt, exp_cnt_b); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_padding();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_single_frame();
      test_padding();
`ifdef SER_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
